// File: rtl/nand_gate_4bits_checker.sv
// Exhaustive stimulus/response checker for a 4-bit NAND gate: walks all 256
// (A,B) pairs, compares y_in after LAT clocks and reports errors and pass/done.
module nand_gate_4bits_checker #(
  parameter int LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  input  logic [3:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_cnt,
  output logic       err_seen,
  output logic [7:0] first_err_idx,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Pipeline arrays keep at least one stage so LAT=0 still elaborates cleanly.
  localparam int         D          = (LAT > 0) ? LAT : 1;
  localparam logic [2:0] DRAIN_LAST = 3'(D - 1);

  state_t     state_q, state_d;
  logic [7:0] idx_q;
  logic [2:0] drain_cnt_q;
  logic [D-1:0] vld_q;
  logic [3:0] exp_q  [D];
  logic [7:0] pidx_q [D];

  logic       launch;
  logic       cmp_valid;
  logic [3:0] cmp_exp;
  logic [7:0] cmp_idx;
  logic       mismatch;

  assign launch    = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign busy      = (state_q == DRIVE) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_cnt == 9'd0);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = DRIVE;
      DRIVE: if (idx_q == 8'hFF) state_d = (LAT > 0) ? DRAIN : DONE;
      DRAIN: if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
      DONE:  if (start) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  // With LAT=0 the compare looks straight at the operands being driven.
  always_comb begin
    if (LAT == 0) begin
      cmp_valid = (state_q == DRIVE);
      cmp_exp   = ~(a_out & b_out);
      cmp_idx   = {a_out, b_out};
    end else begin
      cmp_valid = vld_q[D-1];
      cmp_exp   = exp_q[D-1];
      cmp_idx   = pidx_q[D-1];
    end
  end

  assign mismatch = cmp_valid && (y_in != cmp_exp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= 8'd0;
      drain_cnt_q   <= 3'd0;
      a_out         <= 4'd0;
      b_out         <= 4'd0;
      err_cnt       <= 9'd0;
      err_seen      <= 1'b0;
      first_err_idx <= 8'd0;
      vld_q         <= '0;
      for (int i = 0; i < D; i++) begin
        exp_q[i]  <= 4'd0;
        pidx_q[i] <= 8'd0;
      end
    end else begin
      state_q <= state_d;

      if (launch)                idx_q <= 8'd0;
      else if (state_q == DRIVE) idx_q <= idx_q + 8'd1;

      if (state_d == DRIVE) {a_out, b_out} <= launch ? 8'h00 : idx_q + 8'd1;
      else                  {a_out, b_out} <= 8'h00;

      if (state_q == DRAIN) drain_cnt_q <= drain_cnt_q + 3'd1;
      else                  drain_cnt_q <= 3'd0;

      vld_q[0]  <= (state_q == DRIVE);
      exp_q[0]  <= ~(a_out & b_out);
      pidx_q[0] <= {a_out, b_out};
      for (int i = 1; i < D; i++) begin
        vld_q[i]  <= vld_q[i-1];
        exp_q[i]  <= exp_q[i-1];
        pidx_q[i] <= pidx_q[i-1];
      end

      // A new run wipes the results; otherwise accumulate mismatches.
      if (launch) begin
        err_cnt       <= 9'd0;
        err_seen      <= 1'b0;
        first_err_idx <= 8'd0;
      end else if (mismatch) begin
        err_cnt <= err_cnt + 9'd1;
        if (!err_seen) begin
          err_seen      <= 1'b1;
          first_err_idx <= cmp_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_nand_gate_4bits_checker.sv
// Bench for nand_gate_4bits_checker: three instances (LAT 0/1/2) each drive a
// model gate; expected run results are queued and checked when done rises.
module tb_nand_gate_4bits_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] start_v;
  int unsigned mode;

  always #5 clk = ~clk;

  logic [3:0] a0, b0, y0, a1, b1, y1, a2, b2, y2;
  logic [3:0] s1, s2;
  logic [2:0] busy_v, done_v, pass_v, seen_v;
  logic [8:0] cnt_v  [3];
  logic [7:0] fidx_v [3];
  logic [7:0] ab_v   [3];
  logic [1:0] st0, st1, st2;

  nand_gate_4bits_checker #(.LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_out(a0), .b_out(b0), .y_in(y0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(cnt_v[0]),
    .err_seen(seen_v[0]), .first_err_idx(fidx_v[0]), .state_dbg(st0));
  nand_gate_4bits_checker #(.LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_out(a1), .b_out(b1), .y_in(y1),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(cnt_v[1]),
    .err_seen(seen_v[1]), .first_err_idx(fidx_v[1]), .state_dbg(st1));
  nand_gate_4bits_checker #(.LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_out(a2), .b_out(b2), .y_in(y2),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(cnt_v[2]),
    .err_seen(seen_v[2]), .first_err_idx(fidx_v[2]), .state_dbg(st2));

  assign ab_v[0] = {a0, b0};
  assign ab_v[1] = {a1, b1};
  assign ab_v[2] = {a2, b2};

  // Gate models: u0 sees a combinational NAND with selectable faults,
  // u1 and u2 each see a NAND followed by two register stages.
  always_comb begin
    y0 = ~(a0 & b0);
    if (mode == 1) y0 = y0 & 4'hE;
    else if (mode == 2 && a0 == 4'hA && b0 == 4'h5) y0 = ~y0;
  end

  always @(posedge clk) begin
    s1 <= ~(a1 & b1);
    y1 <= s1;
    s2 <= ~(a2 & b2);
    y2 <= s2;
  end

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // {pad, inst[1:0], pass, err_seen, first_err_idx[7:0], err_cnt[8:0], run_len[9:0]}
  function automatic logic [31:0] pack(input int inst, input bit p, input bit s,
                                       input logic [7:0] f, input int cnt, input int len);
    return {1'b0, 2'(inst), p, s, f, 9'(cnt), 10'(len)};
  endfunction

  // LAT=1 against a 2-stage gate compares vector k with NAND(vector k-1);
  // before vector 0 the gate saw the idle operands 0/0.
  function automatic int lat1_errs();
    int n = 0;
    for (int k = 0; k < 256; k++) begin
      logic [7:0] cur, prv;
      cur = 8'(k);
      prv = (k == 0) ? 8'h00 : 8'(k - 1);
      if (~(cur[7:4] & cur[3:0]) != ~(prv[7:4] & prv[3:0])) n++;
    end
    return n;
  endfunction

  // Monitor: counts busy cycles, checks operand stepping, scores each run.
  int run_len [3] = '{0, 0, 0};
  int ab_bad  [3] = '{0, 0, 0};
  logic [2:0] done_prev = 3'b000;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy_v[i]) begin
        if (run_len[i] < 256) begin
          if (ab_v[i] != 8'(run_len[i])) ab_bad[i]++;
        end else if (ab_v[i] != 8'h00) ab_bad[i]++;
        run_len[i]++;
      end
      if (done_v[i] && !done_prev[i]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", i, -1);
        end else begin
          logic [31:0] w;
          w = exp_q.pop_front();
          chk("run_inst",      i,              int'(w[30:29]));
          chk("pass",          int'(pass_v[i]), int'(w[28]));
          chk("err_seen",      int'(seen_v[i]), int'(w[27]));
          chk("first_err_idx", int'(fidx_v[i]), int'(w[26:19]));
          chk("err_cnt",       int'(cnt_v[i]),  int'(w[18:10]));
          chk("run_len",       run_len[i],      int'(w[9:0]));
          chk("operand_step",  ab_bad[i],       0);
        end
      end
      if (!busy_v[i]) begin
        run_len[i] = 0;
        ab_bad[i]  = 0;
      end
      done_prev[i] = done_v[i];
    end
  end

  task automatic pulse_start(input int inst);
    @(negedge clk);
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst, input string name);
    int n = 0;
    while (!done_v[inst] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, int'(done_v[inst]), 1);
  endtask

  task automatic chk_idle(input int i, input string name);
    chk({name, "_ab"},   int'(ab_v[i]),   0);
    chk({name, "_busy"}, int'(busy_v[i]), 0);
    chk({name, "_done"}, int'(done_v[i]), 0);
    chk({name, "_pass"}, int'(pass_v[i]), 0);
    chk({name, "_cnt"},  int'(cnt_v[i]),  0);
    chk({name, "_seen"}, int'(seen_v[i]), 0);
    chk({name, "_fidx"}, int'(fidx_v[i]), 0);
  endtask

  initial begin
    bit saw_done;
    int n;
    rst_n   = 1'b0;
    start_v = 3'b000;
    mode    = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle(i, "reset");
    rst_n = 1'b1;

    // Ideal gate, with a stray start pulse in the middle of DRIVE.
    exp_q.push_back(pack(0, 1, 0, 8'h00, 0, 256));
    pulse_start(0);
    repeat (50) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, "ideal");

    // Y[0] stuck at 0: every vector whose NAND has bit0 set fails.
    mode = 1;
    exp_q.push_back(pack(0, 0, 1, 8'h00, 192, 256));
    pulse_start(0);
    wait_done(0, "stuck0");

    // Restart from a failing DONE with the gate repaired.
    mode = 0;
    exp_q.push_back(pack(0, 1, 0, 8'h00, 0, 256));
    pulse_start(0);
    chk("restart_done", int'(done_v[0]), 0);
    chk("restart_pass", int'(pass_v[0]), 0);
    chk("restart_cnt",  int'(cnt_v[0]),  0);
    chk("restart_seen", int'(seen_v[0]), 0);
    chk("restart_busy", int'(busy_v[0]), 1);
    wait_done(0, "restart");

    // Single bad vector A=0xA, B=0x5.
    mode = 2;
    exp_q.push_back(pack(0, 0, 1, 8'hA5, 1, 256));
    pulse_start(0);
    wait_done(0, "single");

    // Two-stage gate with matching latency.
    exp_q.push_back(pack(2, 1, 0, 8'h00, 0, 258));
    pulse_start(2);
    wait_done(2, "lat2");

    // Same gate with LAT=1: off by one vector, first disagreement at 0x11.
    exp_q.push_back(pack(1, 0, 1, 8'h11, lat1_errs(), 257));
    pulse_start(1);
    wait_done(1, "lat1");

    // Reset while vector 100 is on the operands.
    mode = 1;
    pulse_start(0);
    n = 0;
    while (ab_v[0] != 8'h64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx100", int'(ab_v[0]), 8'h64);
    chk("pre_reset_errs", int'(cnt_v[0] != 9'd0), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle(0, "midreset");
    saw_done = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done_v[0]) saw_done = 1'b1;
    end
    chk("no_done_after_reset", int'(saw_done), 0);

    mode = 0;
    exp_q.push_back(pack(0, 1, 0, 8'h00, 0, 256));
    pulse_start(0);
    wait_done(0, "after_reset");

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
